// File: rtl/data_bus_timer.sv
// Memory-mapped 64-bit timer/comparator responder on the CPU data bus.
// Prescaled tick, byte-lane register writes, snapshot-paired TIME reads, level IRQ.
module data_bus_timer #(
   parameter logic [31:0] BASE_ADDR    = 32'hFF20_0500,
   parameter logic [31:0] PRESCALE_RST = 32'd49
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        DwReadEnable,
   input  logic        DwWriteEnable,
   input  logic [3:0]  DwByteEnable,
   input  logic [31:0] DwAddress,
   input  logic [31:0] DwWriteData,
   output logic [31:0] DwReadData,
   output logic        oHit,
   output logic        oIRQ
);

   localparam logic [2:0] OFF_TLO  = 3'd0;
   localparam logic [2:0] OFF_THI  = 3'd1;
   localparam logic [2:0] OFF_CLO  = 3'd2;
   localparam logic [2:0] OFF_CHI  = 3'd3;
   localparam logic [2:0] OFF_CTRL = 3'd4;
   localparam logic [2:0] OFF_STAT = 3'd5;
   localparam logic [2:0] OFF_PRE  = 3'd6;

   logic [63:0] timeR;
   logic [63:0] timeNext;
   logic [63:0] cmpR;
   logic [31:0] snapHi;
   logic [31:0] prescale;
   logic [31:0] pcnt;
   logic        ctrlEn;
   logic        ctrlIe;
   logic        pend;

   logic        hit;
   logic [2:0]  offset;
   logic        rdHit;
   logic        wrHit;
   logic        anyLane;
   logic        wrTimeLo;
   logic        wrTimeHi;
   logic        tick;
   logic        match;
   logic        pendClr;
   logic [31:0] rdData;
   logic        unusedAddrBits;

   function automatic logic [31:0] laneMerge(
      input logic [31:0] oldVal,
      input logic [31:0] newVal,
      input logic [3:0]  be
   );
      logic [31:0] res;
      for (int n = 0; n < 4; n++)
         res[8*n +: 8] = be[n] ? newVal[8*n +: 8] : oldVal[8*n +: 8];
      return res;
   endfunction

   assign hit            = (DwAddress[31:5] == BASE_ADDR[31:5]);
   assign oHit           = hit;
   assign offset         = DwAddress[4:2];
   assign unusedAddrBits = ^DwAddress[1:0];
   assign rdHit          = DwReadEnable && hit;
   assign wrHit          = DwWriteEnable && hit;
   assign anyLane        = |DwByteEnable;

   assign wrTimeLo = wrHit && (offset == OFF_TLO) && anyLane;
   assign wrTimeHi = wrHit && (offset == OFF_THI) && anyLane;
   assign tick     = ctrlEn && (pcnt == prescale);
   assign match    = (timeR >= cmpR);
   assign pendClr  = wrHit && (offset == OFF_STAT)
                     && DwByteEnable[0] && DwWriteData[0];
   assign oIRQ     = pend & ctrlIe;

   // Any CPU write into TIME suppresses the tick for the whole 64 bits.
   always_comb begin
      timeNext = timeR;
      if (wrTimeLo || wrTimeHi) begin
         if (wrTimeLo)
            timeNext[31:0] = laneMerge(timeR[31:0], DwWriteData, DwByteEnable);
         if (wrTimeHi)
            timeNext[63:32] = laneMerge(timeR[63:32], DwWriteData, DwByteEnable);
      end else if (tick) begin
         timeNext = timeR + 64'd1;
      end
   end

   always_comb begin
      rdData = '0;
      if (rdHit) begin
         case (offset)
            OFF_TLO:  rdData = timeR[31:0];
            OFF_THI:  rdData = snapHi;
            OFF_CLO:  rdData = cmpR[31:0];
            OFF_CHI:  rdData = cmpR[63:32];
            OFF_CTRL: rdData = {30'b0, ctrlIe, ctrlEn};
            OFF_STAT: rdData = {31'b0, pend};
            OFF_PRE:  rdData = prescale;
            default:  rdData = '0;
         endcase
      end
   end

   assign DwReadData = rdData;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         timeR    <= '0;
         cmpR     <= '1;
         snapHi   <= '0;
         prescale <= PRESCALE_RST;
         pcnt     <= '0;
         ctrlEn   <= 1'b0;
         ctrlIe   <= 1'b0;
         pend     <= 1'b0;
      end else begin
         timeR <= timeNext;
         if (rdHit && (offset == OFF_TLO))
            snapHi <= timeR[63:32];
         if (wrHit && (offset == OFF_CLO))
            cmpR[31:0] <= laneMerge(cmpR[31:0], DwWriteData, DwByteEnable);
         if (wrHit && (offset == OFF_CHI))
            cmpR[63:32] <= laneMerge(cmpR[63:32], DwWriteData, DwByteEnable);
         if (wrHit && (offset == OFF_CTRL) && DwByteEnable[0]) begin
            ctrlEn <= DwWriteData[0];
            ctrlIe <= DwWriteData[1];
         end
         if (wrHit && (offset == OFF_PRE)) begin
            prescale <= laneMerge(prescale, DwWriteData, DwByteEnable);
            pcnt     <= '0;
         end else if (ctrlEn) begin
            pcnt <= tick ? '0 : pcnt + 32'd1;
         end
         // Set beats clear when both happen on one edge.
         pend <= match | (pend & ~pendClr);
      end
   end

endmodule

// File: tb/tb_data_bus_timer.sv
// Scoreboard bench for data_bus_timer: expected read data queued at
// stimulus time, popped and compared when the bus returns data.
module tb_data_bus_timer;

   localparam logic [31:0] BASE = 32'hFF20_0500;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic        DwReadEnable = 1'b0;
   logic        DwWriteEnable = 1'b0;
   logic [3:0]  DwByteEnable = 4'h0;
   logic [31:0] DwAddress = 32'h0;
   logic [31:0] DwWriteData = 32'h0;
   logic [31:0] DwReadData;
   logic        oHit;
   logic        oIRQ;

   int nChecks = 0;
   int nPass = 0;
   logic [31:0] expQ[$];

   data_bus_timer dut (
      .iCLK          (iCLK),
      .iRST          (iRST),
      .DwReadEnable  (DwReadEnable),
      .DwWriteEnable (DwWriteEnable),
      .DwByteEnable  (DwByteEnable),
      .DwAddress     (DwAddress),
      .DwWriteData   (DwWriteData),
      .DwReadData    (DwReadData),
      .oHit          (oHit),
      .oIRQ          (oIRQ)
   );

   always #5 iCLK = ~iCLK;

   task automatic busWrite(input logic [31:0] off, input logic [31:0] data,
                           input logic [3:0] be);
      @(negedge iCLK);
      DwAddress     = BASE + off;
      DwWriteData   = data;
      DwByteEnable  = be;
      DwReadEnable  = 1'b0;
      DwWriteEnable = 1'b1;
      @(posedge iCLK);
      #1 DwWriteEnable = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] addr, output logic [31:0] data,
                          output logic hitObs);
      @(negedge iCLK);
      DwAddress     = addr;
      DwWriteEnable = 1'b0;
      DwReadEnable  = 1'b1;
      #1;
      data   = DwReadData;
      hitObs = oHit;
      @(posedge iCLK);
      #1 DwReadEnable = 1'b0;
   endtask

   task automatic readAllReset(input string tag);
      logic [31:0] rstVals [8];
      logic [31:0] obs;
      logic [31:0] exp;
      logic h;
      rstVals = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'h0, 32'h0, 32'd49, 32'h0};
      for (int i = 0; i < 8; i++) begin
         expQ.push_back(rstVals[i]);
         busRead(BASE + 32'(4 * i), obs, h);
         exp = expQ.pop_front();
         nChecks++;
         if (obs !== exp)
            $display("FAIL %s off%0d: got %h want %h", tag, 4 * i, obs, exp);
         else
            nPass++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] obs;
      logic [31:0] exp;
      logic h;
      DwAddress    = BASE;
      DwReadEnable = 1'b1;
      #1;
      nChecks++;
      if (oIRQ !== 1'b0) $display("FAIL rst_irq: got %b want 0", oIRQ);
      else nPass++;
      nChecks++;
      if (oHit !== 1'b1) $display("FAIL rst_hit: got %b want 1", oHit);
      else nPass++;
      nChecks++;
      if (DwReadData !== 32'h0)
         $display("FAIL rst_rdata: got %h want 0", DwReadData);
      else nPass++;
      DwReadEnable = 1'b0;
      @(negedge iCLK);
      iRST = 1'b1;
      readAllReset("reset_read");
      expQ.push_back(32'h0);
      busRead(BASE + 32'h20, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp || h !== 1'b0)
         $display("FAIL outside_hi: got %h hit %b want %h hit 0", obs, h, exp);
      else nPass++;
      expQ.push_back(32'h0);
      busRead(BASE - 32'h4, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp || h !== 1'b0)
         $display("FAIL outside_lo: got %h hit %b want %h hit 0", obs, h, exp);
      else nPass++;
   endtask

   task automatic test_byte_lane();
      logic [31:0] obs;
      logic [31:0] exp;
      logic h;
      busWrite(32'h08, 32'h00AB_0000, 4'b0100);
      expQ.push_back(32'hFFAB_FFFF);
      busRead(BASE + 32'h08, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL byte_lane: got %h want %h", obs, exp);
      else nPass++;
      busWrite(32'h1C, 32'hFFFF_FFFF, 4'hF);
      expQ.push_back(32'h0);
      busRead(BASE + 32'h1C, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL reserved: got %h want %h", obs, exp);
      else nPass++;
   endtask

   task automatic test_rw_same();
      logic [31:0] obs;
      logic [31:0] exp;
      logic h;
      @(negedge iCLK);
      DwAddress     = BASE + 32'h08;
      DwWriteData   = 32'h1234_5678;
      DwByteEnable  = 4'hF;
      DwReadEnable  = 1'b1;
      DwWriteEnable = 1'b1;
      expQ.push_back(32'hFFAB_FFFF);
      #1 obs = DwReadData;
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL rw_pre: got %h want %h", obs, exp);
      else nPass++;
      @(posedge iCLK);
      #1;
      DwReadEnable  = 1'b0;
      DwWriteEnable = 1'b0;
      expQ.push_back(32'h1234_5678);
      busRead(BASE + 32'h08, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL rw_post: got %h want %h", obs, exp);
      else nPass++;
   endtask

   task automatic test_count();
      logic [31:0] obs;
      logic [31:0] exp;
      logic h;
      busWrite(32'h18, 32'h0, 4'hF);
      busWrite(32'h10, 32'h1, 4'hF);
      repeat (10) @(posedge iCLK);
      expQ.push_back(32'd10);
      busRead(BASE, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL count10: got %0d want %0d", obs, exp);
      else nPass++;
      // read edge and disable edge both still tick
      busWrite(32'h10, 32'h0, 4'hF);
      repeat (20) @(posedge iCLK);
      expQ.push_back(32'd12);
      busRead(BASE, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL frozen: got %0d want %0d", obs, exp);
      else nPass++;
   endtask

   task automatic test_wrap();
      logic [31:0] obs;
      logic [31:0] exp;
      logic h;
      busWrite(32'h04, 32'h0, 4'hF);
      busWrite(32'h00, 32'hFFFF_FFFE, 4'hF);
      busWrite(32'h18, 32'h0, 4'hF);
      busWrite(32'h10, 32'h1, 4'hF);
      repeat (3) @(posedge iCLK);
      expQ.push_back(32'h1);
      expQ.push_back(32'h1);
      busRead(BASE, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL carry_lo: got %h want %h", obs, exp);
      else nPass++;
      busRead(BASE + 32'h04, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL carry_hi: got %h want %h", obs, exp);
      else nPass++;
      busWrite(32'h10, 32'h0, 4'hF);
      busWrite(32'h04, 32'hFFFF_FFFF, 4'hF);
      busWrite(32'h00, 32'hFFFF_FFFF, 4'hF);
      busWrite(32'h10, 32'h1, 4'hF);
      repeat (2) @(posedge iCLK);
      expQ.push_back(32'h1);
      expQ.push_back(32'h0);
      busRead(BASE, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL wrap_lo: got %h want %h", obs, exp);
      else nPass++;
      busRead(BASE + 32'h04, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL wrap_hi: got %h want %h", obs, exp);
      else nPass++;
      busWrite(32'h10, 32'h0, 4'hF);
   endtask

   task automatic test_compare();
      logic [31:0] obs;
      logic [31:0] exp;
      logic h;
      busWrite(32'h04, 32'h0, 4'hF);
      busWrite(32'h00, 32'h0, 4'hF);
      busWrite(32'h0C, 32'h0, 4'hF);
      busWrite(32'h08, 32'd20, 4'hF);
      busWrite(32'h14, 32'h1, 4'h1);
      expQ.push_back(32'h0);
      busRead(BASE + 32'h14, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL pend_clear: got %h want %h", obs, exp);
      else nPass++;
      busWrite(32'h10, 32'h3, 4'hF);
      repeat (20) @(posedge iCLK);
      #1;
      nChecks++;
      if (oIRQ !== 1'b0) $display("FAIL irq_early: got %b want 0", oIRQ);
      else nPass++;
      @(posedge iCLK);
      #1;
      nChecks++;
      if (oIRQ !== 1'b1) $display("FAIL irq_rise: got %b want 1", oIRQ);
      else nPass++;
      busWrite(32'h14, 32'h1, 4'h1);
      nChecks++;
      if (oIRQ !== 1'b1) $display("FAIL set_wins: got %b want 1", oIRQ);
      else nPass++;
      busWrite(32'h0C, 32'hFFFF_FFFF, 4'hF);
      busWrite(32'h14, 32'h1, 4'h1);
      nChecks++;
      if (oIRQ !== 1'b0) $display("FAIL irq_clear: got %b want 0", oIRQ);
      else nPass++;
      busWrite(32'h10, 32'h0, 4'hF);
   endtask

   task automatic test_tick_override();
      logic [31:0] obs;
      logic [31:0] exp;
      logic h;
      busWrite(32'h18, 32'h0, 4'hF);
      busWrite(32'h10, 32'h1, 4'hF);
      busWrite(32'h00, 32'h0000_1000, 4'hF);
      busWrite(32'h00, 32'h0000_00AA, 4'b0001);
      expQ.push_back(32'h0000_10AA);
      busRead(BASE, obs, h);
      exp = expQ.pop_front();
      nChecks++;
      if (obs !== exp) $display("FAIL write_wins: got %h want %h", obs, exp);
      else nPass++;
      busWrite(32'h10, 32'h0, 4'hF);
   endtask

   task automatic test_reset_midcount();
      busWrite(32'h18, 32'd5, 4'hF);
      busWrite(32'h0C, 32'h0, 4'hF);
      busWrite(32'h08, 32'h0, 4'hF);
      busWrite(32'h10, 32'h3, 4'hF);
      for (int i = 0; i < 20 && oIRQ !== 1'b1; i++) @(posedge iCLK);
      #1;
      nChecks++;
      if (oIRQ !== 1'b1) $display("FAIL pre_rst_irq: got %b want 1", oIRQ);
      else nPass++;
      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      #2 iRST = 1'b0;
      #1;
      nChecks++;
      if (oIRQ !== 1'b0) $display("FAIL async_rst_irq: got %b want 0", oIRQ);
      else nPass++;
      @(negedge iCLK);
      iRST = 1'b1;
      readAllReset("post_rst_read");
   endtask

   initial begin
      test_reset();
      test_byte_lane();
      test_rw_same();
      test_count();
      test_wrap();
      test_compare();
      test_tick_override();
      test_reset_midcount();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/data_bus_timer.md
Name: data_bus_timer

Overview:
- Memory-mapped 64-bit timer/comparator that acts as a responder on the CPU data bus, the far end of the bus the CPU drives.
- The CPU reads and writes time, compare, control and prescale registers through byte-enabled word accesses.
- The block raises a level interrupt request when time reaches compare.
- It sits beside data memory and the other peripherals. The system bus mux selects its read data using oHit.

Parameters:
- BASE_ADDR, 32'hFF20_0500, base of the 32-byte register window; bits [4:0] must be 0.
- PRESCALE_RST, 32'd49, reset value of PRESCALE. With a 50 MHz iCLK the timer ticks at 1 MHz.

Ports:
- iCLK  in  1  system clock; all state updates on its rising edge.
- iRST  in  1  reset, asynchronous, active-low.
- DwReadEnable  in  1  CPU read strobe.
- DwWriteEnable  in  1  CPU write strobe.
- DwByteEnable  in  4  byte-lane enables; bit n covers DwWriteData[8n+7:8n].
- DwAddress  in  32  byte address.
- DwWriteData  in  32  write data.
- DwReadData  out  32  read data; combinational.
- oHit  out  1  address falls inside the window; combinational.
- oIRQ  out  1  timer interrupt request, level.

Behaviour:
- Decode:
  - hit = (DwAddress[31:5] == BASE_ADDR[31:5]); oHit = hit.
  - Offset = DwAddress[4:2].
  - DwAddress[1:0] is ignored; accesses are word-aligned by lane.
- Register map (offset, name, reset value):
  - 0x00 TIME_LO, 0.
  - 0x04 TIME_HI, 0; reads return SNAP_HI.
  - 0x08 CMP_LO, FFFF_FFFF.
  - 0x0C CMP_HI, FFFF_FFFF.
  - 0x10 CTRL: bit0 EN, bit1 IE; 0.
  - 0x14 STATUS: bit0 PEND, write-1-to-clear; 0.
  - 0x18 PRESCALE, PRESCALE_RST.
  - 0x1C reserved: reads 0, writes ignored.
  - Unused bits read 0.
- Reads:
  - DwReadData = selected register when (DwReadEnable && hit); otherwise 32'h0. No wait states.
  - At the rising edge where DwReadEnable && hit && offset==0x00, SNAP_HI <= TIME[63:32] of that same cycle.
  - A following TIME_HI read therefore pairs with the TIME_LO already returned.
  - Reading TIME_HI without a prior TIME_LO read returns the stale snapshot; this is intentional.
- Writes:
  - On a rising edge with DwWriteEnable && hit, each lane with DwByteEnable[n]=1 updates byte n of the addressed register.
  - A write to TIME_HI updates TIME[63:32] directly. It does not update SNAP_HI.
  - A write to PRESCALE clears the prescale counter PCNT to 0 on the same edge.
  - STATUS write: if DwByteEnable[0] && DwWriteData[0], PEND is cleared.
- Tick generation (PCNT, 32-bit):
  - If EN=0: PCNT holds and TIME holds.
  - If EN=1 and PCNT != PRESCALE: PCNT increments.
  - If EN=1 and PCNT == PRESCALE: PCNT <= 0 and TIME <= TIME + 1 (full 64-bit carry, wraps FFFF_FFFF_FFFF_FFFF -> 0).
  - PRESCALE=0 ticks every cycle.
- Priority on TIME: a CPU write to a TIME byte overrides the tick increment for that edge.
  - Written bytes take the written value.
  - Unwritten bytes of the written word hold their value; no increment is applied anywhere in TIME that cycle.
- Compare:
  - match = (TIME >= CMP), unsigned 64-bit, evaluated on current register values regardless of EN.
  - PEND <= 1 at the next edge whenever match=1.
  - If a PEND clear and match occur in the same cycle, set wins and PEND stays 1.
- Interrupt: oIRQ = PEND & IE, from registers only, no combinational path from the bus.
- Reset (iRST=0, asynchronous):
  - All registers, PCNT and SNAP_HI go to their reset values.
  - oIRQ=0; DwReadData and oHit follow the bus inputs.
  - Reset mid-count discards partial prescale progress.
  - Deassertion is synchronised externally; it is not handled here.
- Simultaneous read and write to the same register: read returns the pre-edge value; the write takes effect after the edge.

Test Plan:
- Reset, then read every offset -> TIME_LO=0, CMP_LO=FFFF_FFFF, PRESCALE=49, CTRL=0, STATUS=0, 0x1C=0. Read an address outside the window -> oHit=0, DwReadData=0.
- Write PRESCALE=0, CTRL=1, wait 10 cycles, read TIME_LO -> 10 (±1 for the access edge). Set CTRL=0 -> TIME_LO stays frozen over 20 cycles.
- Write TIME_HI=0, TIME_LO=FFFF_FFFE, PRESCALE=0, EN=1. After 3 ticks read TIME_LO then TIME_HI -> TIME_LO=1, TIME_HI snapshot=1. Repeat from all-ones -> wraps to 0.
- Write CMP_HI=0, CMP_LO=20, CTRL=3, PRESCALE=0 -> oIRQ rises one cycle after TIME reaches 20. Write STATUS=1 while TIME>=CMP -> PEND stays 1. Write CMP_HI=FFFF_FFFF, then STATUS=1 -> oIRQ=0.
- Byte-lane write DwByteEnable=4'b0100, data 32'h00AB_0000 to CMP_LO (reset FFFF_FFFF) -> CMP_LO reads FFAB_FFFF. A write to TIME_LO coincident with a tick -> the written value wins, no increment.
- Assert iRST mid-count with CTRL=3 and PEND=1 -> oIRQ drops immediately without a clock. After release, all registers read their reset values.
